// File: rtl/udma_evt_pkg.sv
// Shared types for the uDMA event arbiter: slot FSM states and the
// source-index width helper.
package udma_evt_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } evt_state_e;

    // A single-source configuration still needs a one-bit index.
    function automatic int unsigned calc_src_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/udma_rr_pick.sv
// Combinational round-robin pick: scans req starting just after 'last',
// wrapping modulo N_SRC, and returns the first set bit.
module udma_rr_pick #(
    parameter int N_SRC = 4,
    parameter int SRC_W = 2
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SRC_W-1:0] last,
    output logic             gnt_valid,
    output logic [SRC_W-1:0] gnt_idx,
    output logic [N_SRC-1:0] gnt_onehot
);

    int unsigned      pos;
    logic [SRC_W-1:0] idx;

    always_comb begin
        gnt_valid  = 1'b0;
        gnt_idx    = '0;
        gnt_onehot = '0;
        pos        = 0;
        idx        = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            pos = (int'(last) + k) % N_SRC;
            idx = SRC_W'(pos);
            if (!gnt_valid && req[idx]) begin
                gnt_valid       = 1'b1;
                gnt_idx         = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/udma_evt_arbiter.sv
// Round-robin arbiter sharing the uDMA event-compare port among N_SRC
// requesters, with a single output slot held until the consumer accepts.
module udma_evt_arbiter
    import udma_evt_pkg::*;
#(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 8,
    parameter int SRC_W  = calc_src_w(N_SRC)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_SRC-1:0]        src_valid_i,
    input  logic [N_SRC*DATA_W-1:0] src_data_i,
    output logic [N_SRC-1:0]        src_ready_o,
    input  logic [N_SRC-1:0]        src_en_i,
    output logic                    evt_valid_o,
    output logic [DATA_W-1:0]       evt_data_o,
    output logic [SRC_W-1:0]        evt_src_o,
    input  logic                    evt_ready_i,
    output logic                    busy_o
);

    evt_state_e        state, state_nxt;
    logic [SRC_W-1:0]  r_last;
    logic [DATA_W-1:0] slot_data_p1;
    logic [SRC_W-1:0]  slot_src_p1;

    logic [N_SRC-1:0]  req;
    logic              can_load;
    logic              hs;
    logic              gnt_valid;
    logic [SRC_W-1:0]  gnt_idx;
    logic [N_SRC-1:0]  gnt_onehot;

    assign req      = src_valid_i & src_en_i;
    assign can_load = (state == ST_EMPTY) | evt_ready_i;
    // Reset blocks any accept so no source loses an event into a dropped slot.
    assign hs       = ~rst_i & can_load & gnt_valid;

    udma_rr_pick #(
        .N_SRC (N_SRC),
        .SRC_W (SRC_W)
    ) u_pick (
        .req        (req),
        .last       (r_last),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot)
    );

    assign src_ready_o = hs ? gnt_onehot : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (hs) state_nxt = ST_FULL;
            ST_FULL:  if (evt_ready_i) state_nxt = hs ? ST_FULL : ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Output slot register: loaded only on a source handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_EMPTY;
            r_last       <= SRC_W'(N_SRC - 1);
            slot_data_p1 <= '0;
            slot_src_p1  <= '0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                slot_data_p1 <= src_data_i[gnt_idx*DATA_W +: DATA_W];
                slot_src_p1  <= gnt_idx;
                r_last       <= gnt_idx;
            end
        end
    end

    assign evt_valid_o = (state == ST_FULL);
    assign busy_o      = (state == ST_FULL);
    assign evt_data_o  = slot_data_p1;
    assign evt_src_o   = slot_src_p1;

endmodule
